// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    LOAD,
    WRITE,
    DONE,
    ERROR
  } state_t;

  localparam int          BYTES_PER_WORD = 4;
  localparam logic [31:0] RESET_PC       = 32'd0;

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Packs accepted stream bytes big-endian into 32-bit words; word_valid pulses
// combinationally on the cycle the 4th byte is presented, so word_out is usable that cycle.
module byte_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word_out
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  byte_cnt;
  logic [23:0] shreg;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      byte_cnt <= 2'd0;
      shreg    <= 24'd0;
    end else if (byte_valid) begin
      byte_cnt <= byte_cnt + 2'd1;
      shreg    <= {shreg[15:0], byte_in};
    end
  end

  assign word_valid = byte_valid && (byte_cnt == LAST_BYTE);
  assign word_out   = {shreg, byte_in};

endmodule

// File: rtl/imem_loader.sv
// Boot loader: reads a word-count header then N instruction words from a byte
// stream, writes them to instruction memory from address 0, then releases the core.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_WORDS  = 2 ** ADDR_WIDTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        error,
  output state_t      state_dbg
);

  localparam logic [31:0] MAX_N = 32'(MAX_WORDS);

  state_t                state, state_next;
  logic [ADDR_WIDTH:0]   word_idx, word_idx_inc, n_words;
  logic                  start_ok, byte_accept, clear, word_valid;
  logic [31:0]           word_out;

  // Handshake: a byte transfers on a rising edge where in_valid && in_ready;
  // in_ready depends only on state, never on in_valid.
  assign start_ok     = start && (state == IDLE || state == DONE || state == ERROR);
  assign byte_accept  = in_valid && in_ready;
  assign clear        = reset || start_ok;
  assign word_idx_inc = word_idx + (ADDR_WIDTH + 1)'(1);
  assign state_dbg    = state;

  byte_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .byte_valid (byte_accept),
    .byte_in    (in_data),
    .word_valid (word_valid),
    .word_out   (word_out)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE, ERROR: if (start) state_next = HEADER;
      HEADER: begin
        if (word_valid) begin
          if (word_out == 32'd0)     state_next = DONE;
          else if (word_out > MAX_N) state_next = ERROR;
          else                       state_next = LOAD;
        end
      end
      LOAD:    if (word_valid) state_next = WRITE;
      WRITE:   state_next = (word_idx_inc == n_words) ? DONE : LOAD;
      default: state_next = IDLE;
    endcase
  end

  // cpu_reset rises combinationally with start in DONE so the core is held
  // from the very cycle a reload begins.
  always_comb begin
    in_ready  = (state == HEADER) || (state == LOAD);
    imem_we   = (state == WRITE);
    busy      = (state == HEADER) || (state == LOAD) || (state == WRITE);
    done      = (state == DONE);
    error     = (state == ERROR);
    cpu_reset = reset || (state != DONE) || start;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_idx   <= '0;
      n_words    <= '0;
      imem_addr  <= 32'd0;
      imem_wdata <= 32'd0;
    end else begin
      if (start_ok) word_idx <= '0;
      if (state == HEADER && word_valid && word_out <= MAX_N)
        n_words <= word_out[ADDR_WIDTH:0];
      if (state == LOAD && word_valid) begin
        imem_wdata <= word_out;
        imem_addr  <= RESET_PC + 32'({word_idx, 2'b00});
      end
      if (state == WRITE) word_idx <= word_idx_inc;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: random programs are streamed in and every memory write
// is checked against an (address, data) list derived from the program itself.
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic        clk, reset, start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, imem_we, cpu_reset, busy, done, error;
  logic [31:0] imem_addr, imem_wdata;
  state_t      state_dbg;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];
  logic [31:0] prog_q[$];
  logic [63:0] mon_e;

  imem_loader #(.ADDR_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error), .state_dbg(state_dbg)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish, required finish before 1000000");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write addr=%h data=%h, required no write", imem_addr, imem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== mon_e) begin
          n_err++;
          $display("FAIL write addr=%h data=%h, required addr=%h data=%h",
                   imem_addr, imem_wdata, mon_e[63:32], mon_e[31:0]);
        end
      end
      n_vec++;
      if (in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL ready_in_write in_ready=%b, required 0", in_ready);
      end
    end
  end

  // Driver tasks
  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int  waited;
    bit  taken;
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    waited = 0;
    taken  = 0;
    while (!taken && waited < 40) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      if (in_ready === 1'b1) taken = 1;
      else waited++;
    end
    if (!taken) begin
      n_vec++; n_err++;
      $display("FAIL ready_timeout in_ready=%b, required 1 within 40 cycles", in_ready);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int gap3, input bit rnd, input int poke_at);
    for (int i = 0; i < 4; i++) begin
      int         g;
      logic [7:0] b;
      if (i == poke_at) begin
        @(negedge clk);
        in_valid = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_vec++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
          n_err++;
          $display("FAIL start_in_load busy=%b in_ready=%b, required 1 1", busy, in_ready);
        end
      end
      g = rnd ? int'($urandom_range(0, 2)) : ((i == 2) ? gap3 : 0);
      b = w[31 - 8 * i -: 8];
      send_byte(b, g);
    end
  endtask

  // Streams prog_q as a program; the reference is word i written at byte address 4*i.
  task automatic run_program(input int gap3, input bit rnd, input int poke_at, input bit do_start);
    int n;
    n = prog_q.size();
    if (do_start) begin
      @(negedge clk);
      in_valid = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < n; i++) exp_q.push_back({32'(i * 4), prog_q[i]});
    send_word(32'(n), 0, rnd, -1);
    for (int i = 0; i < n; i++)
      send_word(prog_q[i], (i == 0) ? gap3 : 0, rnd, (i == 0) ? poke_at : -1);
    @(negedge clk);
    in_valid = 1'b0;
    if (n > 0) begin
      n_vec++;
      if (imem_we !== 1'b1) begin
        n_err++;
        $display("FAIL last_write_strobe imem_we=%b, required 1", imem_we);
      end
      @(negedge clk);
    end
    n_vec++;
    if (done !== 1'b1 || cpu_reset !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL done_flags done=%b cpu_reset=%b busy=%b, required 1 0 0", done, cpu_reset, busy);
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL writes_missing remaining=%0d, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  // Scenarios
  task automatic test_reset();
    apply_reset();
    n_vec += 8;
    if (in_ready   !== 1'b0)  begin n_err++; $display("FAIL rst_in_ready got=%b req=0", in_ready); end
    if (imem_we    !== 1'b0)  begin n_err++; $display("FAIL rst_imem_we got=%b req=0", imem_we); end
    if (imem_addr  !== 32'd0) begin n_err++; $display("FAIL rst_addr got=%h req=0", imem_addr); end
    if (imem_wdata !== 32'd0) begin n_err++; $display("FAIL rst_wdata got=%h req=0", imem_wdata); end
    if (cpu_reset  !== 1'b1)  begin n_err++; $display("FAIL rst_cpu_reset got=%b req=1", cpu_reset); end
    if (busy       !== 1'b0)  begin n_err++; $display("FAIL rst_busy got=%b req=0", busy); end
    if (done       !== 1'b0)  begin n_err++; $display("FAIL rst_done got=%b req=0", done); end
    if (error      !== 1'b0)  begin n_err++; $display("FAIL rst_error got=%b req=0", error); end
  endtask

  task automatic test_basic();
    prog_q = '{32'h20080005, 32'h8C090004};
    run_program(0, 0, -1, 1);
  endtask

  task automatic test_gap();
    prog_q = '{$urandom(), $urandom()};
    run_program(3, 0, -1, 1);
  endtask

  task automatic test_zero();
    prog_q.delete();
    run_program(0, 0, -1, 1);
  endtask

  task automatic test_error();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_word(32'd257, 0, 0, -1);
    @(negedge clk);
    in_valid = 1'b0;
    n_vec++;
    if (error !== 1'b1 || cpu_reset !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL error_state error=%b cpu_reset=%b in_ready=%b busy=%b, required 1 1 0 0",
               error, cpu_reset, in_ready, busy);
    end
    repeat (3) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'($urandom());
    end
    n_vec++;
    if (error !== 1'b1) begin
      n_err++;
      $display("FAIL error_sticky error=%b, required 1", error);
    end
    @(negedge clk);
    in_valid = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_vec++;
    if (busy !== 1'b1 || error !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL error_restart busy=%b error=%b in_ready=%b, required 1 0 1", busy, error, in_ready);
    end
    prog_q = '{$urandom()};
    run_program(0, 0, -1, 0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    prog_q = '{$urandom(), $urandom(), $urandom()};
    exp_q.push_back({32'd0, prog_q[0]});
    send_word(32'd3, 0, 0, -1);
    send_word(prog_q[0], 0, 0, -1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || cpu_reset !== 1'b1 || imem_we !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset busy=%b cpu_reset=%b imem_we=%b in_ready=%b done=%b, required 0 1 0 0 0",
               busy, cpu_reset, imem_we, in_ready, done);
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL mid_reset_first_write remaining=%0d, required 0", exp_q.size());
    end
    exp_q.delete();
    prog_q = '{$urandom()};
    run_program(0, 0, -1, 1);
  endtask

  task automatic test_start_ignored();
    prog_q = '{$urandom(), $urandom()};
    run_program(0, 0, 2, 1);
  endtask

  task automatic test_start_in_done();
    @(negedge clk);
    in_valid = 1'b0;
    n_vec++;
    if (cpu_reset !== 1'b0) begin
      n_err++;
      $display("FAIL done_before_start cpu_reset=%b, required 0", cpu_reset);
    end
    start = 1'b1;
    #1;
    n_vec++;
    if (cpu_reset !== 1'b1) begin
      n_err++;
      $display("FAIL start_cpu_reset cpu_reset=%b, required 1", cpu_reset);
    end
    @(negedge clk);
    start = 1'b0;
    n_vec++;
    if (busy !== 1'b1 || in_ready !== 1'b1 || cpu_reset !== 1'b1) begin
      n_err++;
      $display("FAIL restart_header busy=%b in_ready=%b cpu_reset=%b, required 1 1 1",
               busy, in_ready, cpu_reset);
    end
    prog_q = '{$urandom()};
    run_program(0, 0, -1, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      int n;
      n = $urandom_range(1, 8);
      prog_q.delete();
      for (int i = 0; i < n; i++) prog_q.push_back($urandom());
      run_program(0, 1, -1, 1);
    end
  endtask

  task automatic test_max_words();
    prog_q.delete();
    for (int i = 0; i < 256; i++) prog_q.push_back($urandom());
    run_program(0, 0, -1, 1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    test_reset();
    test_basic();
    test_gap();
    test_zero();
    test_error();
    test_reset_mid();
    test_start_ignored();
    test_start_in_done();
    test_random();
    test_max_words();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the instruction memory that the processor core reads.
- Accepts a byte stream: a 4-byte header holding the word count N, then N 32-bit instruction words.
- Writes each word into instruction memory at consecutive word addresses from 0.
- Holds the core in reset (cpu_reset) until the load completes, then releases it so fetch starts at pc = 0.

Parameters:
- ADDR_WIDTH, 8, instruction memory depth in words is 2**ADDR_WIDTH.
- MAX_WORDS, 2**ADDR_WIDTH, largest legal N; a header above this is an error.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  1-cycle pulse; begins a load from IDLE, DONE or ERROR.
- in_valid  in  1  in_data holds a byte.
- in_data  in  8  stream byte.
- in_ready  out  1  loader can take a byte this cycle.
- imem_we  out  1  instruction memory write strobe, 1-cycle pulse.
- imem_addr  out  32  byte address, always word-aligned (word_idx << 2).
- imem_wdata  out  32  instruction word.
- cpu_reset  out  1  reset to the processor core.
- busy  out  1  high in HEADER, LOAD, WRITE.
- done  out  1  high in DONE.
- error  out  1  high in ERROR.

Behaviour:
- Reset values: in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, cpu_reset 1, busy 0, done 0, error 0. State is IDLE; all counters are 0.
- Reset is synchronous and wins over every other input in the same cycle. Reset mid-load abandons the load, returns to IDLE and holds cpu_reset at 1. Words already written are not erased.
- A byte is accepted only on a cycle where in_valid & in_ready. When in_ready is 0, in_valid is ignored and the byte is not consumed.
- Byte assembly is big-endian: accepted bytes 0..3 land in bits [31:24], [23:16], [15:8], [7:0]. The byte counter wraps 3 -> 0.

States:
- IDLE: in_ready 0. start -> HEADER, clearing word_idx and the byte counter.
- HEADER: in_ready 1. On the 4th accepted byte:
  - N == 0 -> DONE.
  - N > MAX_WORDS -> ERROR.
  - otherwise latch N and go to LOAD.
- LOAD: in_ready 1. The 4th accepted byte -> WRITE. Register imem_wdata = assembled word and imem_addr = word_idx << 2.
- WRITE: lasts exactly 1 cycle.
  - imem_we = 1, in_ready 0, word_idx increments.
  - If the incremented word_idx == N -> DONE, else -> LOAD.
  - imem_we is therefore high exactly the cycle after the accepting edge of the 4th byte.
  - Peak throughput is one word per 5 cycles.
- DONE: cpu_reset 0 starting with the first cycle in DONE, and never earlier than the cycle after the final imem_we. in_ready 0. start -> HEADER and cpu_reset returns to 1 in that same cycle.
- ERROR: cpu_reset 1, in_ready 0; sticky. Exits only on start (-> HEADER) or reset.

Other rules:
- start is ignored in HEADER, LOAD and WRITE.
- cpu_reset is 1 in every state except DONE.
- imem_addr and imem_wdata hold their last value outside WRITE. They are meaningful only while imem_we = 1.
- No word address ever exceeds (MAX_WORDS-1) << 2.
- word_idx is ADDR_WIDTH+1 bits wide, so N = MAX_WORDS terminates without wrapping.

Decomposition:
- Package imem_loader_pkg holds:
  - state enum: IDLE, HEADER, LOAD, WRITE, DONE, ERROR.
  - constant BYTES_PER_WORD = 4.
  - constant RESET_PC = 32'd0.
- One sub-module, byte_assembler:
  - Inputs: clk, reset, clear, byte_valid, byte_in[7:0].
  - Outputs: word_valid (1-cycle pulse on the 4th byte), word_out[31:0].
  - Contents: 2-bit counter and shift register.
- The loader FSM instantiates byte_assembler and drives clear on start and on reset.

Test Plan:
- Reset, start, then bytes 00 00 00 02 | 20 08 00 05 | 8C 09 00 04 with in_valid held high:
  - exactly two imem_we pulses: (addr 0x0, data 0x20080005), then (addr 0x4, data 0x8C090004).
  - done = 1 and cpu_reset = 0 on the cycle after the second pulse.
  - in_ready = 0 during each WRITE cycle.
- Header 00 00 00 00 -> no imem_we, DONE on the cycle after the 4th header byte, cpu_reset = 0.
- With ADDR_WIDTH = 8, header 00 00 01 01 (N = 257) -> error = 1, cpu_reset = 1, in_ready = 0. A following start re-enters HEADER with busy = 1.
- Valid/ready gaps:
  - Drop in_valid for 3 cycles between bytes 2 and 3 of a word -> the word assembles correctly with no extra imem_we.
  - Drive bytes while in_ready = 0 (IDLE, WRITE) -> those bytes are not consumed.
- Reset asserted after the first word is written in a 3-word load -> next cycle in IDLE, cpu_reset = 1, busy = 0, imem_we = 0. A fresh start with N = 1 writes addr 0x0 again.
- start pulsed in LOAD -> ignored, word_idx unchanged. start pulsed in DONE -> cpu_reset = 1 in that same cycle and a new header is accepted.
